// File: rtl/spi_master.sv
// spi_master -- SPI mode-0 master datapath with one transmit register per slave.
//
// The serial bit clock s_clk is oversampled by clk; it is never used as a clock.
// Each frame shifts DATA_W bits MSB-first out of tx_reg[selected slave] on mosi.
// The bits received on miso are written back into that same tx_reg when the
// frame completes, so the next frame to that slave echoes what it sent.
//
// Ports:
//   clk         system clock; all state changes on its rising edge
//   reset_n     synchronous active-low reset
//   s_clk       serial bit clock (asynchronous, treated as data)
//   miso        serial data from the selected slave
//   m_chip_sel  one-hot slave select, bit i selects slave i
//   mosi        registered serial data to the selected slave
module spi_master #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       NUM_SLAVES = 4,
    parameter logic [DATA_W-1:0] TX_INIT    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_clk,
    input  logic                  miso,
    input  logic [NUM_SLAVES-1:0] m_chip_sel,
    output logic                  mosi
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CSC_W = $clog2(NUM_SLAVES + 1);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic               s_meta;
    logic               s_sync;
    logic               s_hist;
    logic               rise;
    logic               fall;

    logic [CSC_W-1:0]   cs_count;
    logic               cs_valid;
    logic [SEL_W-1:0]   sel_idx;
    logic [SEL_W-1:0]   cur_sel;
    logic               abort;

    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  tx_shift;
    logic [DATA_W-1:0]  rx_shift;
    logic [DATA_W-1:0]  tx_reg [NUM_SLAVES];

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_hist <= 1'b0;
        end else begin
            s_meta <= s_clk;
            s_sync <= s_meta;
            s_hist <= s_sync;
        end
    end

    always_comb begin
        rise = s_sync & ~s_hist;
        fall = ~s_sync & s_hist;
    end

    // Chip select is valid only when exactly one bit is set.
    always_comb begin
        cs_count = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (m_chip_sel[i]) begin
                cs_count = cs_count + 1'b1;
                sel_idx  = SEL_W'(i);
            end
        end
        cs_valid = (cs_count == CSC_W'(1));
        abort    = !cs_valid || (sel_idx != cur_sel);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_valid) state_nxt = LOAD;
            LOAD:    state_nxt = abort ? IDLE : SHIFT;
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (rise && (bit_cnt == CNT_W'(DATA_W - 1))) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi     <= 1'b0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            cur_sel  <= '0;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                tx_reg[i] <= TX_INIT;
            end
        end else begin
            case (state)
                IDLE: begin
                    mosi <= 1'b0;
                    if (cs_valid) cur_sel <= sel_idx;
                end
                LOAD: begin
                    if (abort) begin
                        mosi <= 1'b0;
                    end else begin
                        tx_shift <= tx_reg[cur_sel];
                        mosi     <= tx_reg[cur_sel][DATA_W-1];
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        mosi <= 1'b0;
                    end else if (rise) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else if (fall && (bit_cnt != '0) && (bit_cnt < CNT_W'(DATA_W))) begin
                        // A fall before the first rise leaves the MSB on mosi.
                        tx_shift <= tx_shift << 1;
                        mosi     <= tx_shift[DATA_W-2];
                    end
                end
                DONE: begin
                    tx_reg[cur_sel] <= rx_shift;
                    mosi            <= 1'b0;
                end
                default: mosi <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- self-checking bench for spi_master.
//
// A slave model drives s_clk/miso from the negative clk edge and records mosi.
// Because the DUT sees s_clk through a synchronizer, the slave samples mosi and
// advances miso three clk periods after each s_clk rise it drives; at that
// point the DUT has just consumed miso and mosi still carries the current bit.
// The reference model is simply an array of per-slave registers: a frame to
// slave s must send model_tx[s] MSB-first and, if completed, replaces it with
// the byte received on miso.
module tb_spi_master;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_SLAVES = 4;

    logic                  clk_tb = 1'b0;
    logic                  reset_n;
    logic                  s_clk;
    logic                  miso;
    logic [NUM_SLAVES-1:0] m_chip_sel;
    logic                  mosi;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] model_tx [NUM_SLAVES];

    typedef struct {
        logic [NUM_SLAVES-1:0] cs;
        logic                  exp_mosi;
    } cs_vec_t;

    cs_vec_t cs_table [10];

    always #5 clk_tb = ~clk_tb;

    spi_master #(
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .TX_INIT    (8'hA5)
    ) dut (
        .clk        (clk_tb),
        .reset_n    (reset_n),
        .s_clk      (s_clk),
        .miso       (miso),
        .m_chip_sel (m_chip_sel),
        .mosi       (mosi)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            check($sformatf("%s tx_reg[%0d]", tag, i), 32'(dut.tx_reg[i]), 32'(model_tx[i]));
        end
    endtask

    // Runs nbits s_clk cycles (low for lo clks, high for hi clks) and returns
    // the mosi bits seen. Returns on the sample tick of the last bit without
    // driving s_clk on that tick.
    task automatic run_frame(input int nbits, input logic [DATA_W-1:0] miso_bits,
                             input int lo, input int hi, output logic [DATA_W-1:0] got);
        int t = 0;
        int n = 0;
        int p = lo + hi;
        got  = '0;
        miso = miso_bits[DATA_W-1];
        while (n < nbits) begin
            if (t >= 3 && ((t - 3) % p) == lo) begin
                got[3'(DATA_W - 1 - n)] = mosi;
                n++;
                if (n < int'(DATA_W)) miso = miso_bits[3'(DATA_W - 1 - n)];
            end
            if (n >= nbits) break;
            s_clk = ((t % p) >= lo);
            @(negedge clk_tb);
            t++;
            if (t > 2000) begin
                compared++;
                mismatched++;
                $display("FAIL frame_timeout: got %0d bits, expected %0d", n, nbits);
                break;
            end
        end
    endtask

    // Drops chip select right after a completed frame and checks the echo.
    task automatic end_frame(input int sel, input logic [DATA_W-1:0] rx, input string tag);
        m_chip_sel = '0;
        model_tx[sel] = rx;
        @(negedge clk_tb);
        check({tag, " mosi_after"}, 32'(mosi), 32'(0));
        check_regs(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] rx;
        int                sel;
        int                lo;
        int                hi;

        cs_table[0] = '{4'h0, 1'b0};
        cs_table[1] = '{4'h1, 1'b1};
        cs_table[2] = '{4'h2, 1'b1};
        cs_table[3] = '{4'h3, 1'b0};
        cs_table[4] = '{4'h4, 1'b1};
        cs_table[5] = '{4'h8, 1'b1};
        cs_table[6] = '{4'h5, 1'b0};
        cs_table[7] = '{4'hF, 1'b0};
        cs_table[8] = '{4'hC, 1'b0};
        cs_table[9] = '{4'h6, 1'b0};

        for (int i = 0; i < int'(NUM_SLAVES); i++) model_tx[i] = 8'hA5;

        // Reset state
        reset_n    = 1'b0;
        s_clk      = 1'b0;
        miso       = 1'b0;
        m_chip_sel = '0;
        repeat (3) @(negedge clk_tb);
        check("reset mosi", 32'(mosi), 32'(0));
        check_regs("reset");
        reset_n = 1'b1;
        @(negedge clk_tb);

        // Chip-select decode: valid selects reach SHIFT with the MSB on mosi
        for (int i = 0; i < 10; i++) begin
            m_chip_sel = cs_table[i].cs;
            repeat (2) @(negedge clk_tb);
            check($sformatf("cs_table[%0d] cs=%0h mosi", i, cs_table[i].cs),
                  32'(mosi), 32'(cs_table[i].exp_mosi));
            m_chip_sel = '0;
            repeat (3) @(negedge clk_tb);
            check($sformatf("cs_table[%0d] idle mosi", i), 32'(mosi), 32'(0));
        end
        check_regs("cs_table");

        // Invalid selects with s_clk toggling: nothing happens
        for (int k = 0; k < 30; k++) begin
            m_chip_sel = (k < 15) ? 4'h3 : 4'h0;
            s_clk      = ((k % 3) == 2);
            miso       = k[0];
            @(negedge clk_tb);
            check($sformatf("invalid_cs k=%0d mosi", k), 32'(mosi), 32'(0));
        end
        s_clk = 1'b0;
        repeat (4) @(negedge clk_tb);
        check_regs("invalid_cs");

        // Slave 0, s_clk period 3, miso=1: A5 out, FF echoed, then all ones out
        m_chip_sel = 4'h1;
        run_frame(8, 8'hFF, 2, 1, got);
        check("frame1 mosi", 32'(got), 32'(8'hA5));
        model_tx[0] = 8'hFF;
        @(negedge clk_tb);
        check("frame1 echo tx_reg[0]", 32'(dut.tx_reg[0]), 32'(8'hFF));
        run_frame(8, 8'h3C, 2, 1, got);
        check("frame2 mosi", 32'(got), 32'(8'hFF));
        end_frame(0, 8'h3C, "frame2");

        // Mid-frame switch to slave 1 aborts; slave 1 then gets its own data
        m_chip_sel = 4'h1;
        run_frame(3, 8'hFF, 2, 1, got);
        check("abort partial mosi", 32'(got[7:5]), 32'(model_tx[0][7:5]));
        m_chip_sel = 4'h2;
        @(negedge clk_tb);
        check("abort mosi", 32'(mosi), 32'(0));
        check_regs("abort");
        run_frame(8, 8'h96, 2, 1, got);
        check("after_abort slave1 mosi", 32'(got), 32'(8'hA5));
        end_frame(1, 8'h96, "after_abort");

        // Slave 3 receives alternating bits starting with 0, then echoes them
        m_chip_sel = 4'h8;
        run_frame(8, 8'h55, 2, 1, got);
        check("slave3 frame1 mosi", 32'(got), 32'(8'hA5));
        end_frame(3, 8'h55, "slave3_a");
        check("slave3 tx_reg", 32'(dut.tx_reg[3]), 32'(8'h55));
        m_chip_sel = 4'h8;
        run_frame(8, 8'h0F, 3, 2, got);
        check("slave3 frame2 mosi", 32'(got), 32'(8'h55));
        end_frame(3, 8'h0F, "slave3_b");

        // Reset in the middle of SHIFT discards the frame
        m_chip_sel = 4'h1;
        run_frame(4, 8'hC3, 2, 2, got);
        reset_n = 1'b0;
        @(negedge clk_tb);
        for (int i = 0; i < int'(NUM_SLAVES); i++) model_tx[i] = 8'hA5;
        check("midreset mosi", 32'(mosi), 32'(0));
        check_regs("midreset");
        m_chip_sel = '0;
        s_clk      = 1'b0;
        reset_n    = 1'b1;
        repeat (4) @(negedge clk_tb);

        // s_clk stuck: FSM sits in SHIFT holding the MSB, frame never completes
        m_chip_sel = 4'h1;
        repeat (2) @(negedge clk_tb);
        for (int k = 0; k < 40; k++) begin
            miso = k[0];
            check($sformatf("stuck_sclk k=%0d mosi", k), 32'(mosi), 32'(1));
            @(negedge clk_tb);
        end
        m_chip_sel = '0;
        @(negedge clk_tb);
        check("stuck_sclk release mosi", 32'(mosi), 32'(0));
        check_regs("stuck_sclk");

        // Randomized frames against the register-array model
        for (int f = 0; f < 20; f++) begin
            s_clk = 1'($urandom_range(0, 1));
            miso  = 1'b0;
            repeat (4) @(negedge clk_tb);
            sel        = int'($urandom_range(0, NUM_SLAVES - 1));
            lo         = int'($urandom_range(1, 4));
            hi         = int'($urandom_range(1, 4));
            rx         = DATA_W'($urandom);
            m_chip_sel = NUM_SLAVES'(1 << sel);
            run_frame(8, rx, lo, hi, got);
            check($sformatf("rand%0d slave%0d lo%0d hi%0d mosi", f, sel, lo, hi),
                  32'(got), 32'(model_tx[sel]));
            end_frame(sel, rx, $sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 DATA_W, 8, frame length in bits; SHALL be a parameter.
REQ-002 NUM_SLAVES, 4, number of slave selects; SHALL be a parameter.
REQ-003 TX_INIT, 8'hA5, reset value of every per-slave transmit register; SHALL be a parameter.
REQ-004 clk  input  1  system clock; all state SHALL change only on rising clk.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 s_clk  input  1  serial bit clock, asynchronous to clk; SHALL be treated as a data input, never as a clock.
REQ-007 miso  input  1  serial data from the selected slave.
REQ-008 m_chip_sel  input  NUM_SLAVES  one-hot slave select; bit i selects slave i.
REQ-009 mosi  output  1  serial data to the selected slave, registered.

Function
REQ-010 s_clk SHALL pass through a 2-flop synchronizer plus a history flop; rise = sync high and history low, fall = sync low and history high, each a 1-clk pulse.
REQ-011 cs_valid SHALL be true when m_chip_sel has exactly one bit set; sel_idx = index of that bit.
REQ-012 One DATA_W-bit transmit register per slave, tx_reg[0..NUM_SLAVES-1].
REQ-013 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: mosi=0; if cs_valid, latch sel_idx into cur_sel and go to LOAD next cycle.
REQ-015 LOAD (1 cycle): tx_shift <= tx_reg[cur_sel]; mosi <= its MSB; bit_cnt <= 0; rx_shift <= 0; go to SHIFT.
REQ-016 SHIFT, on rise: rx_shift <= {rx_shift[DATA_W-2:0], miso}; bit_cnt increments; when the DATA_W-th bit is sampled, go to DONE.
REQ-017 SHIFT, on fall, when bit_cnt between 1 and DATA_W-1: tx_shift shifts left by one; mosi <= next bit (MSB first, SPI mode 0).
REQ-018 A fall before the first rise of a frame SHALL NOT shift; mosi holds the MSB.
REQ-019 DONE (1 cycle): tx_reg[cur_sel] <= rx_shift (echo); mosi <= 0; go to IDLE; if cs is still valid, IDLE starts the next frame immediately.
REQ-020 Abort: in LOAD or SHIFT, if cs_valid is false or sel_idx != cur_sel, go to IDLE next cycle with mosi=0; no tx_reg is updated.
REQ-021 tx_reg of non-selected slaves SHALL never change except on reset.
REQ-022 rise and fall SHALL NOT occur in the same cycle; rise/fall in IDLE, LOAD or DONE SHALL be ignored.
REQ-023 bit_cnt SHALL be wide enough to hold DATA_W and SHALL never wrap within a frame.

Reset
REQ-024 When reset_n=0 at a rising clk: state=IDLE; mosi=0; bit_cnt=0; tx_shift=0; rx_shift=0; synchronizer flops=0; every tx_reg=TX_INIT.
REQ-025 Reset SHALL take priority over all other activity, including mid-frame; a frame interrupted by reset is discarded.
REQ-026 Outputs are undefined only before the first rising clk with reset_n=0.

Verification
REQ-027 The bench SHALL cover: reset 3 clks, m_chip_sel=4'h1, miso=1, s_clk period 3 clk -> first frame mosi = A5 MSB-first (1,0,1,0,0,1,0,1); DONE writes tx_reg[0]=FF; second frame mosi = all ones.
REQ-028 The bench SHALL cover: m_chip_sel=4'h0 or 4'h3 -> FSM stays IDLE, mosi=0, no tx_reg changes.
REQ-029 The bench SHALL cover: m_chip_sel switched 4'h1 -> 4'h2 mid-frame -> abort within 1 clk, tx_reg[0] unchanged, new frame to slave 1 sends A5.
REQ-030 The bench SHALL cover: m_chip_sel=4'h8, miso toggling 0,1 per bit starting with 0 -> after DONE, tx_reg[3]=8'h55; next frame to slave 3 sends 0,1,0,1,0,1,0,1.
REQ-031 The bench SHALL cover: reset_n=0 asserted mid-SHIFT -> next clk state IDLE, mosi=0, all tx_reg=A5.
REQ-032 The bench SHALL cover: s_clk held constant with m_chip_sel=4'h1 -> FSM stays in SHIFT, mosi holds the MSB (1), no DONE.
